// File: rtl/boc_sig_gen.sv
// ---------------------------------------------------------------------------------------------
// boc_sig_gen
//   BOC(1,1) modulated PRN signal generator. A half-chip NCO paces a truncated 2046-chip Gold
//   code built from two 11-stage LFSRs. Each code chip is XORed with the subcarrier, the current
//   data bit and the sign of a quadrature-free carrier NCO. The result is emitted as a
//   +/-AMP signed sample.
//
// Ports
//   rx_clk       in   clock, rising edge
//   rx_rst       in   asynchronous active-high reset
//   rx_en        in   run request (IDLE -> SEEK -> RUN; low returns to IDLE)
//   rx_code_fcw  in   half-chip NCO frequency control word
//   rx_car_fcw   in   carrier NCO frequency control word
//   rx_init_phs  in   start half-chip offset (>= 4092 treated as 0)
//   rx_bit       in   data bit
//   rx_bit_vld   in   rx_bit valid
//   tx_bit_rdy   out  one-deep bit buffer is empty
//   tx_sig       out  signed IF sample
//   tx_sig_vld   out  tx_sig valid (one per RUN cycle)
//   tx_half_idx  out  half-chip index of tx_sig
//   tx_prn_sop   out  first sample of a PRN period
//   tx_prn_eop   out  last sample of a PRN period
//   tx_busy      out  code phase seek in progress
//   tx_bit_urun  out  sticky data underrun flag
// ---------------------------------------------------------------------------------------------
module boc_sig_gen #(
    parameter int unsigned       ACC_WIDTH     = 32,
    parameter int unsigned       PRN_PHS_WIDTH = 12,
    parameter int unsigned       G2_TAP_A      = 1,
    parameter int unsigned       G2_TAP_B      = 3,
    parameter int unsigned       PRDS_PER_BIT  = 20,
    parameter logic signed [7:0] AMP           = 8'sd64
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic                     rx_en,
    input  logic [ACC_WIDTH-1:0]     rx_code_fcw,
    input  logic [ACC_WIDTH-1:0]     rx_car_fcw,
    input  logic [PRN_PHS_WIDTH-1:0] rx_init_phs,
    input  logic                     rx_bit,
    input  logic                     rx_bit_vld,
    output logic                     tx_bit_rdy,
    output logic [7:0]               tx_sig,
    output logic                     tx_sig_vld,
    output logic [PRN_PHS_WIDTH-1:0] tx_half_idx,
    output logic                     tx_prn_sop,
    output logic                     tx_prn_eop,
    output logic                     tx_busy,
    output logic                     tx_bit_urun
);

    localparam int unsigned SeekW   = PRN_PHS_WIDTH - 1;
    localparam int unsigned BitCntW = (PRDS_PER_BIT > 1) ? $clog2(PRDS_PER_BIT) : 1;

    localparam logic [11:1]              LfsrInit = 11'b01010101010;
    localparam logic [PRN_PHS_WIDTH-1:0] HalfLast = PRN_PHS_WIDTH'(4091);
    localparam logic [PRN_PHS_WIDTH-1:0] PhsLimit = PRN_PHS_WIDTH'(4092);
    localparam logic [BitCntW-1:0]       BitLast  = BitCntW'(PRDS_PER_BIT - 1);
    localparam logic [SeekW-1:0]         SeekOne  = SeekW'(1);

    typedef enum logic [1:0] {StIdle, StSeek, StRun} state_e;

    // Fibonacci LFSRs: bit 11 is the output stage, feedback enters at bit 1.
    function automatic logic [11:1] g1_step(input logic [11:1] g);
        return {g[10:1], g[1] ^ g[7] ^ g[8] ^ g[9] ^ g[10] ^ g[11]};
    endfunction

    function automatic logic [11:1] g2_step(input logic [11:1] g);
        return {g[10:1], g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[5] ^ g[8] ^ g[9] ^ g[11]};
    endfunction

    state_e                   state_q, state_d;
    logic [11:1]              g1_q, g1_d, g2_q, g2_d;
    logic [ACC_WIDTH-1:0]     code_acc_q, code_acc_d, car_acc_q, car_acc_d;
    logic [PRN_PHS_WIDTH-1:0] half_idx_q, half_idx_d;
    logic [SeekW-1:0]         seek_cnt_q, seek_cnt_d;
    logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                     buf_full_q, buf_full_d, buf_bit_q, buf_bit_d;
    logic                     cur_bit_q, cur_bit_d, sop_pend_q, sop_pend_d;
    logic [7:0]               sig_q, sig_d;
    logic                     sig_vld_q, sig_vld_d;
    logic [PRN_PHS_WIDTH-1:0] half_out_q, half_out_d;
    logic                     sop_q, sop_d, eop_q, eop_d, busy_q, busy_d;
    logic                     urun_q, urun_d, rdy_q, rdy_d;

    logic [ACC_WIDTH:0] code_sum;
    logic               chip, car_sign, sym, xfer, consume;

    assign code_sum = {1'b0, code_acc_q} + {1'b0, rx_code_fcw};
    assign chip     = g1_q[11] ^ g2_q[G2_TAP_A] ^ g2_q[G2_TAP_B];
    assign car_sign = car_acc_q[ACC_WIDTH-1] ^ car_acc_q[ACC_WIDTH-2];
    assign sym      = chip ^ half_idx_q[0] ^ cur_bit_q ^ car_sign;
    assign xfer     = rx_bit_vld & rdy_q;

    always_comb begin
        state_d    = state_q;
        g1_d       = g1_q;
        g2_d       = g2_q;
        code_acc_d = code_acc_q;
        car_acc_d  = car_acc_q;
        half_idx_d = half_idx_q;
        seek_cnt_d = seek_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        buf_full_d = buf_full_q;
        buf_bit_d  = buf_bit_q;
        cur_bit_d  = cur_bit_q;
        sop_pend_d = sop_pend_q;
        sig_d      = sig_q;
        half_out_d = half_out_q;
        urun_d     = urun_q;
        sig_vld_d  = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        consume    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_en) begin
                    state_d    = StSeek;
                    g1_d       = LfsrInit;
                    g2_d       = LfsrInit;
                    code_acc_d = '0;
                    car_acc_d  = '0;
                    half_idx_d = (rx_init_phs >= PhsLimit) ? '0 : rx_init_phs;
                    seek_cnt_d = half_idx_d[PRN_PHS_WIDTH-1:1];
                    bit_cnt_d  = '0;
                end
            end
            StSeek: begin
                if (!rx_en) begin
                    state_d = StIdle;
                end else begin
                    // One LFSR step per cycle; a zero count still spends one cycle here.
                    if (seek_cnt_q != '0) begin
                        g1_d       = g1_step(g1_q);
                        g2_d       = g2_step(g2_q);
                        seek_cnt_d = seek_cnt_q - SeekOne;
                    end
                    if (seek_cnt_q <= SeekOne) begin
                        state_d    = StRun;
                        sop_pend_d = (half_idx_q == '0);
                    end
                end
            end
            StRun: begin
                if (!rx_en) begin
                    state_d = StIdle;
                end else begin
                    sig_d      = sym ? 8'(-AMP) : 8'(AMP);
                    sig_vld_d  = 1'b1;
                    half_out_d = half_idx_q;
                    sop_d      = sop_pend_q;
                    sop_pend_d = 1'b0;
                    code_acc_d = code_sum[ACC_WIDTH-1:0];
                    car_acc_d  = car_acc_q + rx_car_fcw;
                    if (code_sum[ACC_WIDTH]) begin
                        if (half_idx_q == HalfLast) begin
                            // Truncated code: restart both LFSRs instead of running to 2047.
                            eop_d      = 1'b1;
                            half_idx_d = '0;
                            g1_d       = LfsrInit;
                            g2_d       = LfsrInit;
                            sop_pend_d = 1'b1;
                            if (bit_cnt_q == BitLast) begin
                                bit_cnt_d = '0;
                                consume   = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                            end
                        end else begin
                            half_idx_d = half_idx_q + PRN_PHS_WIDTH'(1);
                            // Odd -> even advance is a new chip.
                            if (half_idx_q[0]) begin
                                g1_d = g1_step(g1_q);
                                g2_d = g2_step(g2_q);
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Consume before accept so a bit arriving on the boundary lands in the buffer.
        if (consume) begin
            if (buf_full_q) begin
                cur_bit_d  = buf_bit_q;
                buf_full_d = 1'b0;
            end else begin
                cur_bit_d = 1'b0;
                urun_d    = 1'b1;
            end
        end
        if (xfer) begin
            buf_bit_d  = rx_bit;
            buf_full_d = 1'b1;
        end

        busy_d = (state_d == StSeek);
        rdy_d  = ~buf_full_d;
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q    <= StIdle;
            g1_q       <= LfsrInit;
            g2_q       <= LfsrInit;
            code_acc_q <= '0;
            car_acc_q  <= '0;
            half_idx_q <= '0;
            seek_cnt_q <= '0;
            bit_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            buf_bit_q  <= 1'b0;
            cur_bit_q  <= 1'b0;
            sop_pend_q <= 1'b0;
            sig_q      <= '0;
            sig_vld_q  <= 1'b0;
            half_out_q <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            urun_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            code_acc_q <= code_acc_d;
            car_acc_q  <= car_acc_d;
            half_idx_q <= half_idx_d;
            seek_cnt_q <= seek_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_full_q <= buf_full_d;
            buf_bit_q  <= buf_bit_d;
            cur_bit_q  <= cur_bit_d;
            sop_pend_q <= sop_pend_d;
            sig_q      <= sig_d;
            sig_vld_q  <= sig_vld_d;
            half_out_q <= half_out_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            urun_q     <= urun_d;
            rdy_q      <= rdy_d;
        end
    end

    assign tx_bit_rdy  = rdy_q;
    assign tx_sig      = sig_q;
    assign tx_sig_vld  = sig_vld_q;
    assign tx_half_idx = half_out_q;
    assign tx_prn_sop  = sop_q;
    assign tx_prn_eop  = eop_q;
    assign tx_busy     = busy_q;
    assign tx_bit_urun = urun_q;

endmodule

// File: tb/tb_boc_sig_gen.sv
// ---------------------------------------------------------------------------------------------
// tb_boc_sig_gen
//   Self-checking bench for boc_sig_gen (PRDS_PER_BIT = 2 to keep bit periods short). A
//   behavioural model predicts every output each cycle from a precomputed 2046-entry chip table,
//   integer NCO arithmetic and a simple bit-buffer rule.
// ---------------------------------------------------------------------------------------------
module tb_boc_sig_gen;

    localparam int Prds = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] code_fcw = '0;
    logic [31:0] car_fcw = '0;
    logic [11:0] init_phs = '0;
    logic        bit_i = 1'b0;
    logic        bit_vld = 1'b0;

    logic        tx_bit_rdy, tx_sig_vld, tx_prn_sop, tx_prn_eop, tx_busy, tx_bit_urun;
    logic [7:0]  tx_sig;
    logic [11:0] tx_half_idx;

    boc_sig_gen #(
        .PRDS_PER_BIT(Prds)
    ) dut (
        .rx_clk      (clk),
        .rx_rst      (rst),
        .rx_en       (en),
        .rx_code_fcw (code_fcw),
        .rx_car_fcw  (car_fcw),
        .rx_init_phs (init_phs),
        .rx_bit      (bit_i),
        .rx_bit_vld  (bit_vld),
        .tx_bit_rdy  (tx_bit_rdy),
        .tx_sig      (tx_sig),
        .tx_sig_vld  (tx_sig_vld),
        .tx_half_idx (tx_half_idx),
        .tx_prn_sop  (tx_prn_sop),
        .tx_prn_eop  (tx_prn_eop),
        .tx_busy     (tx_busy),
        .tx_bit_urun (tx_bit_urun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- reference model ----------------
    bit          chip_tab[2046];
    int          m_state;            // 0 idle, 1 seek, 2 run
    int          m_seek, m_idx, m_wraps;
    longint      m_code, m_car;
    bit          m_buf_full, m_buf, m_cur, m_urun, m_sop_pend;
    logic [7:0]  e_sig;
    logic [11:0] e_idx;
    logic        e_vld, e_sop, e_eop, e_busy, e_rdy, e_urun;

    logic [25:0] obs, expv;
    assign obs  = {tx_sig, tx_sig_vld, tx_half_idx, tx_prn_sop, tx_prn_eop, tx_busy,
                   tx_bit_rdy, tx_bit_urun};
    assign expv = {e_sig, e_vld, e_idx, e_sop, e_eop, e_busy, e_rdy, e_urun};

    task automatic build_chips();
        bit          g1[12];
        bit          g2[12];
        bit          f1, f2;
        logic [10:0] iv;
        iv = 11'b01010101010;
        for (int k = 1; k <= 11; k++) begin
            g1[k] = iv[k-1];
            g2[k] = iv[k-1];
        end
        for (int c = 0; c < 2046; c++) begin
            chip_tab[c] = g1[11] ^ g2[1] ^ g2[3];
            f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
            f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
            for (int k = 11; k >= 2; k--) begin
                g1[k] = g1[k-1];
                g2[k] = g2[k-1];
            end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_seek = 0; m_idx = 0; m_wraps = 0; m_code = 0; m_car = 0;
        m_buf_full = 0; m_buf = 0; m_cur = 0; m_urun = 0; m_sop_pend = 0;
        e_sig = '0; e_idx = '0; e_vld = 0; e_sop = 0; e_eop = 0; e_busy = 0; e_rdy = 0;
        e_urun = 0;
    endtask

    task automatic model_step();
        bit     xfer, consume, sym, csign;
        longint sum;
        xfer    = bit_vld && e_rdy;
        consume = 0;
        e_vld = 0; e_sop = 0; e_eop = 0;
        case (m_state)
            0: if (en) begin
                m_state = 1; m_code = 0; m_car = 0; m_wraps = 0;
                m_idx  = (int'(init_phs) >= 4092) ? 0 : int'(init_phs);
                m_seek = m_idx / 2;
            end
            1: if (!en) m_state = 0;
               else begin
                   if (m_seek <= 1) begin
                       m_state = 2;
                       m_sop_pend = (m_idx == 0);
                   end
                   if (m_seek > 0) m_seek--;
               end
            default: if (!en) m_state = 0;
               else begin
                   csign = ((m_car >> 31) ^ (m_car >> 30)) & 1;
                   sym   = chip_tab[m_idx / 2] ^ bit'(m_idx % 2) ^ m_cur ^ csign;
                   e_sig = sym ? 8'hC0 : 8'h40;
                   e_vld = 1; e_idx = 12'(m_idx); e_sop = m_sop_pend; m_sop_pend = 0;
                   sum    = m_code + longint'(code_fcw);
                   m_code = sum % 64'h1_0000_0000;
                   m_car  = (m_car + longint'(car_fcw)) % 64'h1_0000_0000;
                   if (sum >= 64'h1_0000_0000) begin
                       if (m_idx == 4091) begin
                           e_eop = 1; m_idx = 0; m_sop_pend = 1; m_wraps++;
                           if (m_wraps == Prds) begin m_wraps = 0; consume = 1; end
                       end else m_idx++;
                   end
               end
        endcase
        if (consume) begin
            if (m_buf_full) begin m_cur = m_buf; m_buf_full = 0; end
            else begin m_cur = 0; m_urun = 1; end
        end
        if (xfer) begin m_buf = bit_i; m_buf_full = 1; end
        e_busy = (m_state == 1);
        e_rdy  = !m_buf_full;
        e_urun = m_urun;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (obs !== 26'd0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, 26'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if (tx_bit_rdy !== 1'b1 || obs !== expv) begin
            n_fail++; $display("FAIL reset_release_rdy got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic test_offset0();
        int nvld = 0, first_eop = -1, sop_after = -1, busy_n = 0;
        init_phs = 12'd0; code_fcw = 32'h8000_0000; car_fcw = $urandom; en = 1'b1;
        for (int i = 0; i < 8200; i++) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL offset0 cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
            if (tx_busy) busy_n++;
            if (tx_sig_vld) begin
                nvld++;
                if (tx_prn_eop && first_eop < 0) first_eop = nvld;
                if (tx_prn_sop && nvld > 1 && sop_after < 0) sop_after = nvld;
            end
        end
        n_tests++;
        if (first_eop != 8184) begin
            n_fail++; $display("FAIL offset0_eop_pos got=%0d exp=%0d", first_eop, 8184);
        end
        n_tests++;
        if (sop_after != 8185) begin
            n_fail++; $display("FAIL offset0_sop_next got=%0d exp=%0d", sop_after, 8185);
        end
        n_tests++;
        if (busy_n != 1) begin
            n_fail++; $display("FAIL offset0_busy got=%0d exp=%0d", busy_n, 1);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_seek_offset();
        int busy_n = 0, first_idx = -1;
        init_phs = 12'd100; code_fcw = $urandom; car_fcw = $urandom; en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i > 100 && (i % 7) == 0) begin code_fcw = $urandom; car_fcw = $urandom; end
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL seek100 cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
            if (tx_busy) busy_n++;
            if (tx_sig_vld && first_idx < 0) first_idx = int'(tx_half_idx);
        end
        n_tests++;
        if (busy_n != 50) begin
            n_fail++; $display("FAIL seek100_busy got=%0d exp=%0d", busy_n, 50);
        end
        n_tests++;
        if (first_idx != 100) begin
            n_fail++; $display("FAIL seek100_first_idx got=%0d exp=%0d", first_idx, 100);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_init_wrap_and_en_drop();
        int busy_n = 0;
        bit got_first = 0;
        bit first_sop = 0;
        init_phs = 12'd4095; code_fcw = 32'hC000_0000; car_fcw = $urandom; en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            en = !(i >= 30 && i < 34);
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL init4095 cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
            if (i < 30 && tx_busy) busy_n++;
            if (tx_sig_vld && !got_first) begin got_first = 1; first_sop = tx_prn_sop; end
        end
        n_tests++;
        if (busy_n != 1 || first_sop !== 1'b1) begin
            n_fail++; $display("FAIL init4095_seek got=busy%0d/sop%0d exp=busy1/sop1",
                               busy_n, first_sop);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        int left = 10;
        bit done = 0;
        init_phs = 12'($urandom_range(0, 4091));
        code_fcw = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF); car_fcw = $urandom;
        bit_vld = 1'b0; en = 1'b1;
        for (int i = 0; i < 12000 && !done; i++) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
            if (m_urun) begin
                left--;
                if (left == 0) done = 1;
            end
        end
        n_tests++;
        if (tx_bit_urun !== 1'b1 || !done) begin
            n_fail++; $display("FAIL underrun_flag got=%b exp=%b", tx_bit_urun, 1'b1);
        end
    endtask

    task automatic test_boundary_bit();
        int  hits = 0;
        bit  pred;
        for (int i = 0; i < 20000 && hits < 2; i++) begin
            pred = (m_state == 2) && en && (m_idx == 4091) && (m_wraps == Prds - 1) &&
                   ((m_code + longint'(code_fcw)) >= 64'h1_0000_0000);
            bit_vld = pred;
            bit_i   = 1'b1;
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL boundary cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
            if (pred) begin
                hits++;
                if (hits == 1) begin
                    n_tests++;
                    if (tx_bit_rdy !== 1'b0) begin
                        n_fail++; $display("FAIL boundary_refill got=%b exp=%b", tx_bit_rdy, 1'b0);
                    end
                end
            end
        end
        bit_vld = 1'b0;
        n_tests++;
        if (hits != 2) begin
            n_fail++; $display("FAIL boundary_hits got=%0d exp=%0d", hits, 2);
        end
    endtask

    task automatic test_random_bits();
        for (int i = 0; i < 9000; i++) begin
            bit_vld = ($urandom_range(0, 999) == 0);
            bit_i   = $urandom_range(0, 1);
            if ((i % 500) == 0) begin
                code_fcw = 32'hE000_0000 | ($urandom & 32'h1FFF_FFFF);
                car_fcw  = $urandom;
            end
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random_bits cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
        bit_vld = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (obs !== 26'd0) begin
            n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, 26'd0);
        end
        en = 1'b0;
        #2;
        rst = 1'b0;
        init_phs = 12'd37; code_fcw = 32'h9000_0000; car_fcw = 32'h1234_5678; en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        build_chips();
        model_reset();
        test_reset();
        test_offset0();
        test_seek_offset();
        test_init_wrap_and_en_drop();
        test_underrun();
        test_boundary_bit();
        test_random_bits();
        test_rst_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
